// File: rtl/servo_pwm_gen.sv
// -----------------------------------------------------------------------------
// servo_pwm_gen
//
// Turns the 12-bit position ramp (0..MAX_POS) into a hobby-servo PWM frame.
// Each frame is PERIOD_CYCLES long. It opens with a high pulse of
//   W = MIN_PULSE_CYCLES + pos * SCALE
// cycles and stays low for the rest of the frame. The position is clamped
// to MAX_POS and latched only on the frame-start edge, so a pulse can never
// change width while it is being driven.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous reset, active low (0 = reset)
//   enable       1 = run frames back to back; 0 = stop once the current frame ends
//   cntd_val     requested servo position (values above MAX_POS are clamped)
//   pwm_out      servo PWM pin (registered)
//   frame_start  one-cycle strobe on the first cycle of every frame (registered)
//   active       high while a frame is in progress (registered)
//   pos_latched  clamped position in use for the current frame
// -----------------------------------------------------------------------------
module servo_pwm_gen #(
    parameter int unsigned PERIOD_CYCLES    = 2000000,
    parameter int unsigned MIN_PULSE_CYCLES = 100000,
    parameter int unsigned SCALE            = 33,
    parameter int unsigned MAX_POS          = 3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [11:0] cntd_val,
    output logic        pwm_out,
    output logic        frame_start,
    output logic        active,
    output logic [11:0] pos_latched
);

    localparam int unsigned CNT_W = $clog2(PERIOD_CYCLES);
    localparam int unsigned W_MAX = MIN_PULSE_CYCLES + MAX_POS * SCALE;
    localparam int unsigned W_W   = $clog2(W_MAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [11:0]       pos_q, pos_d;
    logic              pwm_q, pwm_d;
    logic              fs_q, fs_d;
    logic              act_q, act_d;

    logic [W_W-1:0]    pulse_w;
    logic [CNT_W-1:0]  pulse_last;
    logic [11:0]       pos_clamped;
    logic              start;

    // Pulse width is derived from the latched position, never from the live input.
    assign pulse_w     = W_W'(MIN_PULSE_CYCLES + SCALE * 32'(pos_q));
    assign pulse_last  = CNT_W'(pulse_w) - CNT_W'(1);
    assign pos_clamped = (32'(cntd_val) > MAX_POS) ? 12'(MAX_POS) : cntd_val;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        pos_d   = pos_q;
        pwm_d   = pwm_q;
        fs_d    = 1'b0;
        act_d   = act_q;
        start   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    start = 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == pulse_last) begin
                    state_d = LOW;
                    pwm_d   = 1'b0;
                end
            end
            LOW: begin
                if (cnt_q == CNT_W'(PERIOD_CYCLES - 1)) begin
                    // enable is only looked at here, so frames are never truncated.
                    if (enable) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                        act_d   = 1'b0;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                pwm_d   = 1'b0;
                act_d   = 1'b0;
                cnt_d   = '0;
            end
        endcase

        // Frame start shares one path for the IDLE entry and the back-to-back wrap.
        if (start) begin
            state_d = HIGH;
            cnt_d   = '0;
            pos_d   = pos_clamped;
            pwm_d   = 1'b1;
            fs_d    = 1'b1;
            act_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pos_q   <= '0;
            pwm_q   <= 1'b0;
            fs_q    <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            pwm_q   <= pwm_d;
            fs_q    <= fs_d;
            act_q   <= act_d;
        end
    end

    assign pwm_out     = pwm_q;
    assign frame_start = fs_q;
    assign active      = act_q;
    assign pos_latched = pos_q;

    // The pulse must always end before the frame does.
    a_pulse_fits : assert property (@(posedge clk) disable iff (!rst)
        (32'(pulse_w) < PERIOD_CYCLES));

endmodule

// File: tb/tb_servo_pwm_gen.sv
// -----------------------------------------------------------------------------
// tb_servo_pwm_gen
//
// Self-checking bench for servo_pwm_gen using shortened frame parameters.
// Expected pulse widths, periods and latched positions come from the
// arithmetic rules W = MIN + min(pos, MAX_POS) * SCALE and period = PERIOD.
// -----------------------------------------------------------------------------
module tb_servo_pwm_gen;

    localparam int P    = 3200;
    localparam int MINP = 64;
    localparam int SC   = 1;
    localparam int MAXP = 3000;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [11:0] cntd_val;
    logic        pwm_out;
    logic        frame_start;
    logic        active;
    logic [11:0] pos_latched;

    int checks = 0;
    int errors = 0;

    servo_pwm_gen #(
        .PERIOD_CYCLES   (P),
        .MIN_PULSE_CYCLES(MINP),
        .SCALE           (SC),
        .MAX_POS         (MAXP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .cntd_val   (cntd_val),
        .pwm_out    (pwm_out),
        .frame_start(frame_start),
        .active     (active),
        .pos_latched(pos_latched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int clampv(input int v);
        return (v > MAXP) ? MAXP : v;
    endfunction

    function automatic int wexp(input int v);
        return MINP + clampv(v) * SC;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Entered at the negedge where frame_start is seen for a frame that latched v.
    // Measures the high time and the distance to the next frame_start; nxt is
    // applied during LOW so the following frame latches it.
    task automatic run_frame(input int v, input int nxt, input int junk);
        int hi;
        int lo;
        check("fs_pos_latched", 32'(pos_latched), 32'(clampv(v)));
        check("fs_active", 32'(active), 32'd1);
        check("fs_pwm", 32'(pwm_out), 32'd1);
        hi = 0;
        while (pwm_out === 1'b1 && hi < P) begin
            hi++;
            if (hi == wexp(v) / 2) cntd_val = 12'(junk);
            @(negedge clk);
        end
        check("high_cycles", 32'(hi), 32'(wexp(v)));
        check("low_fs_clear", 32'(frame_start), 32'd0);
        cntd_val = 12'(nxt);
        lo = 0;
        while (frame_start !== 1'b1 && lo < P) begin
            lo++;
            @(negedge clk);
        end
        check("period", 32'(hi + lo), 32'(P));
    endtask

    initial begin
        int v;
        int nxt;
        int n;
        int fs_seen;
        int pwm_seen;

        rst      = 1'b0;
        enable   = 1'b1;
        cntd_val = 12'd1234;

        // Reset held with enable high: nothing may start.
        repeat (5) begin
            @(negedge clk);
            check("rst_pwm", 32'(pwm_out), 32'd0);
            check("rst_active", 32'(active), 32'd0);
            check("rst_pos", 32'(pos_latched), 32'd0);
            check("rst_fs", 32'(frame_start), 32'd0);
        end

        cntd_val = 12'd0;
        rst      = 1'b1;
        @(negedge clk);
        check("first_fs", 32'(frame_start), 32'd1);

        // Directed endpoints, clamp, and a mid-pulse step 1500 -> 2000.
        run_frame(0, 3000, $urandom_range(0, 4095));
        run_frame(3000, 4095, $urandom_range(0, 4095));
        run_frame(4095, 1500, $urandom_range(0, 4095));
        run_frame(1500, 2000, 2000);
        v = 2000;
        for (int i = 0; i < 3; i++) begin
            nxt = int'($urandom_range(0, 4095));
            run_frame(v, nxt, $urandom_range(0, 4095));
            v = nxt;
        end

        // Drop enable 10 cycles into a frame: the frame still runs to full length.
        check("drop_fs", 32'(frame_start), 32'd1);
        check("drop_pos", 32'(pos_latched), 32'(clampv(v)));
        n = 0;
        repeat (10) begin
            @(negedge clk);
            n++;
        end
        enable = 1'b0;
        while (active === 1'b1 && n < P + 10) begin
            @(negedge clk);
            n++;
        end
        check("drop_frame_len", 32'(n), 32'(P));
        check("idle_pwm", 32'(pwm_out), 32'd0);
        fs_seen  = 0;
        pwm_seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (frame_start !== 1'b0) fs_seen++;
            if (pwm_out !== 1'b0 || active !== 1'b0) pwm_seen++;
        end
        check("idle_no_fs", 32'(fs_seen), 32'd0);
        check("idle_quiet", 32'(pwm_seen), 32'd0);

        // Restart from IDLE: strobe and pulse visible right after the sampling edge.
        v        = int'($urandom_range(0, 4095));
        cntd_val = 12'(v);
        enable   = 1'b1;
        @(negedge clk);
        check("restart_fs", 32'(frame_start), 32'd1);
        check("restart_pwm", 32'(pwm_out), 32'd1);
        check("restart_pos", 32'(pos_latched), 32'(clampv(v)));

        // Reset mid-pulse aborts the frame immediately.
        repeat (30) @(negedge clk);
        check("pre_rst_pwm", 32'(pwm_out), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_pwm", 32'(pwm_out), 32'd0);
        check("midrst_active", 32'(active), 32'd0);
        check("midrst_pos", 32'(pos_latched), 32'd0);
        check("midrst_fs", 32'(frame_start), 32'd0);
        repeat (2) @(negedge clk);
        nxt      = int'($urandom_range(0, 4095));
        cntd_val = 12'(nxt);
        rst      = 1'b1;
        @(negedge clk);
        check("post_rst_fs", 32'(frame_start), 32'd1);
        run_frame(nxt, nxt, $urandom_range(0, 4095));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/servo_pwm_gen.md
Name: servo_pwm_gen

Overview:
Downstream consumer of the 12-bit position ramp (0..3000) produced by the position counter. Converts the position into a standard hobby-servo PWM frame: 20 ms period, 1.0 ms to 2.0 ms high pulse, at 100 MHz (Basys3).
- Position is sampled once per frame, so the pulse width never changes mid-pulse.
- Drives the servo signal pin directly and gives frame/status strobes to the SPI steering logic.

Parameters:
- PERIOD_CYCLES, 2000000, frame length in clk cycles (20 ms @ 100 MHz).
- MIN_PULSE_CYCLES, 100000, high time for position 0 (1 ms).
- SCALE, 33, added high-time cycles per position LSB.
- MAX_POS, 3000, largest legal position; larger inputs clamp to this.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
- enable  input  1  1 = generate frames; 0 = stop after the current frame completes.
- cntd_val  input  12  requested servo position, 0..MAX_POS.
- pwm_out  output  1  servo PWM signal.
- frame_start  output  1  one-cycle strobe on the first cycle of every frame.
- active  output  1  high while a frame is in progress.
- pos_latched  output  12  clamped position used by the current frame.

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE.
  - pwm_out=0, frame_start=0, active=0, pos_latched=0.
  - Frame counter = 0.
  - Reset has priority over everything and aborts a frame mid-pulse. pwm_out is 0 from the first cycle after the reset edge.
- States: IDLE, HIGH, LOW.
- Frame counter: 21 bits, unsigned, range 0..PERIOD_CYCLES-1.
- Pulse width W = MIN_PULSE_CYCLES + pos_latched*SCALE.
  - 18-bit unsigned; maximum 100000 + 3000*33 = 199000.
  - No overflow is possible at the defaults.
- Clamp: pos_latched <= (cntd_val > MAX_POS) ? MAX_POS : cntd_val.
- Frame start: entered from IDLE when enable=1, or by wrapping at the end of a frame while enable=1. In the same edge:
  - latch the clamped position;
  - counter <= 0;
  - frame_start <= 1 for exactly one cycle;
  - active <= 1;
  - state <= HIGH.
- Latency: IDLE with enable=1 sampled at edge N gives pwm_out=1 and frame_start=1 visible after edge N.
- HIGH state:
  - pwm_out=1; counter increments every cycle.
  - When counter == W-1, next state is LOW.
  - The pulse is therefore exactly W cycles.
- LOW state:
  - pwm_out=0; counter increments every cycle.
  - When counter == PERIOD_CYCLES-1, the frame ends:
    - enable=1: start a new frame on the same edge (no gap; frames are back-to-back, exactly PERIOD_CYCLES apart).
    - enable=0: state <= IDLE, active <= 0.
- Deasserting enable mid-frame does not truncate the frame. It is only sampled at the frame end.
- cntd_val changes mid-frame are ignored until the next frame start. The value present on the frame-start edge is the one used.
- pwm_out, frame_start and active are registered outputs (no combinational paths from inputs).
- W is always less than PERIOD_CYCLES (parameter-legality requirement, checked by a simulation assertion).

Test Plan:
1. Reset: rst=0 for 5 cycles with enable=1 -> pwm_out=0, active=0, pos_latched=0 throughout; first frame_start on the first edge after rst=1.
2. cntd_val=0, enable=1 -> pwm_out high for exactly 100000 cycles, low for 1900000; frame_start pulses 2000000 cycles apart.
3. cntd_val=3000 -> high time 199000 cycles. cntd_val=4095 -> pos_latched=3000, high time 199000 (clamp).
4. cntd_val steps 1500->2000 at cycle 50000 of a frame -> current pulse stays 149500 cycles; next frame 166000 cycles.
5. enable dropped at cycle 10 of a frame -> frame completes its full 2000000 cycles, then IDLE with active=0, pwm_out=0, no further frame_start.
6. rst=0 asserted mid-HIGH at cycle 30000 -> pwm_out=0 from the next cycle; after rst=1 with enable=1, a fresh full frame starts with a correct pulse width.
